// File: rtl/mac_dot_product_unit.sv
// mac_dot_product_unit: serial multiply-accumulate dot product feeding a result-memory write port.
// Build option MAC_SAT_EN: saturating accumulation with a sticky sat_flag (wrapping otherwise).
module mac_dot_product_unit #(
  parameter int DATA_W = 16,
  parameter int ACC_W = 32,
  parameter int N = 3,
  parameter int NUM_RESULTS = 9,
  parameter int IDX_W = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [N*DATA_W-1:0]   a_i,
  input  logic [N*DATA_W-1:0]   b_j,
  input  logic [IDX_W-1:0]      in_idx,
  output logic                  res_we,
  output logic [IDX_W-1:0]      res_addr,
  output logic [ACC_W-1:0]      res_data,
  output logic                  busy,
  output logic                  done,
  output logic                  sat_flag
);
  localparam int K_W = (N > 1) ? $clog2(N) : 1;
  typedef enum logic [1:0] {IDLE, MAC, WRITE} state_t;
  state_t state, state_nxt;
  logic [N*DATA_W-1:0] a_r, b_r;
  logic [IDX_W-1:0] idx_r, count;
  logic [ACC_W-1:0] acc, acc_nxt;
  logic [K_W-1:0] k;
  logic [2*DATA_W-1:0] prod;
  logic accept, last, idx_ok;
  assign accept = in_valid && in_ready && !start;
  assign last = k == K_W'(N - 1);
  assign idx_ok = idx_r < IDX_W'(NUM_RESULTS);
  assign prod = a_r[k*DATA_W +: DATA_W] * b_r[k*DATA_W +: DATA_W];
`ifdef MAC_SAT_EN
  logic [ACC_W:0] sum;
  logic ovf;
  assign sum = {1'b0, acc} + (ACC_W + 1)'(prod);
  assign ovf = sum[ACC_W];
  assign acc_nxt = ovf ? '1 : sum[ACC_W-1:0];
  always_ff @(posedge clk)
    sat_flag <= !rst && !start && (sat_flag || (state == MAC && ovf));
`else
  assign acc_nxt = acc + ACC_W'(prod);
  assign sat_flag = 1'b0;
`endif
  always_ff @(posedge clk)
    state <= rst ? IDLE : state_nxt;
  always_comb
    state_nxt = start ? IDLE :
                state == IDLE ? (accept ? MAC : IDLE) :
                state == MAC ? (last ? WRITE : MAC) : IDLE;
  always_comb begin
    in_ready = state == IDLE && !done;
    busy = state != IDLE;
    res_we = state == WRITE && idx_ok;
  end
  // res_addr/res_data load only on entry to a real write so they hold between writes
  always_ff @(posedge clk)
    if (rst) begin
      a_r <= '0;
      b_r <= '0;
      idx_r <= '0;
      acc <= '0;
      k <= '0;
      count <= '0;
      done <= 1'b0;
      res_addr <= '0;
      res_data <= '0;
    end else begin
      if (accept) begin
        a_r <= a_i;
        b_r <= b_j;
        idx_r <= in_idx;
        acc <= '0;
        k <= '0;
      end
      if (state == MAC) begin
        acc <= acc_nxt;
        k <= k + 1'b1;
      end
      if (state == MAC && last && !start && idx_ok) begin
        res_addr <= idx_r;
        res_data <= acc_nxt;
      end
      if (start) begin
        count <= '0;
        done <= 1'b0;
      end else if (state == WRITE && idx_ok) begin
        count <= count + 1'b1;
        done <= done || (count + 1'b1 == IDX_W'(NUM_RESULTS));
      end
    end
endmodule

// File: tb/tb_mac_dot_product_unit.sv
// tb_mac_dot_product_unit: randomized and directed checks of mac_dot_product_unit against an arithmetic model.
module tb_mac_dot_product_unit;
  localparam int DATA_W = 16, ACC_W = 32, N = 3, NR = 9, IDX_W = 4;
  logic clk = 1'b0;
  logic rst, start, in_valid, in_ready, res_we, busy, done, sat_flag;
  logic [N*DATA_W-1:0] a_i, b_j;
  logic [IDX_W-1:0] in_idx, res_addr;
  logic [ACC_W-1:0] res_data;
  int n_chk = 0, n_fail = 0;
  int exp_count;
  bit exp_done, exp_sat;
  logic [IDX_W-1:0] last_addr;
  logic [ACC_W-1:0] last_data;
  always #5 clk = ~clk;
  mac_dot_product_unit #(.DATA_W(DATA_W), .ACC_W(ACC_W), .N(N), .NUM_RESULTS(NR), .IDX_W(IDX_W)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .a_i(a_i), .b_j(b_j), .in_idx(in_idx), .res_we(res_we), .res_addr(res_addr),
    .res_data(res_data), .busy(busy), .done(done), .sat_flag(sat_flag)
  );
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [N*DATA_W-1:0] pack(input logic [DATA_W-1:0] x0, x1, x2);
    return {x2, x1, x0};
  endfunction
  task automatic model(input logic [N*DATA_W-1:0] a, b, output logic [ACC_W-1:0] r, output bit ovf);
    longint unsigned s = 0;
    ovf = 0;
    for (int i = 0; i < N; i++) begin
      s += 64'(a[i*DATA_W +: DATA_W]) * 64'(b[i*DATA_W +: DATA_W]);
`ifdef MAC_SAT_EN
      if (s > 64'hFFFF_FFFF) begin
        s = 64'hFFFF_FFFF;
        ovf = 1;
      end
`endif
    end
    r = s[ACC_W-1:0];
  endtask
  task automatic clear_model();
    exp_count = 0;
    exp_done = 0;
    exp_sat = 0;
  endtask
  task automatic do_start();
    start = 1;
    @(negedge clk);
    start = 0;
    clear_model();
    check("start_busy", busy, 0);
    check("start_done", done, 0);
    check("start_ready", in_ready, 1);
    check("start_sat", sat_flag, 0);
  endtask
  task automatic check_reset_outputs();
    check("rst_ready", in_ready, 1);
    check("rst_we", res_we, 0);
    check("rst_addr", res_addr, 0);
    check("rst_data", res_data, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_sat", sat_flag, 0);
  endtask
  // mode 0: full transaction, 1: start pulse at k=1, 2: rst during WRITE
  task automatic txn(input logic [N*DATA_W-1:0] a, b, input logic [IDX_W-1:0] idx, input int mode);
    logic [ACC_W-1:0] r;
    bit ovf;
    model(a, b, r, ovf);
    a_i = a;
    b_j = b;
    in_idx = idx;
    in_valid = 1;
    check("ready_idle", in_ready, 1);
    @(negedge clk);
    in_valid = 0;
    for (int c = 0; c < N; c++) begin
      check("busy_mac", busy, 1);
      check("ready_mac", in_ready, 0);
      check("we_mac", res_we, 0);
      if (mode == 1 && c == 1) begin
        start = 1;
        @(negedge clk);
        start = 0;
        clear_model();
        check("abort_busy", busy, 0);
        check("abort_we", res_we, 0);
        check("abort_done", done, 0);
        check("abort_ready", in_ready, 1);
        return;
      end
      @(negedge clk);
    end
    exp_sat |= ovf;
    check("we", res_we, idx < NR);
    check("busy_wr", busy, 1);
    check("ready_wr", in_ready, 0);
    check("sat", sat_flag, exp_sat);
    if (idx < NR) begin
      check("addr", res_addr, idx);
      check("data", res_data, r);
      last_addr = idx;
      last_data = r;
    end
    if (mode == 2) begin
      rst = 1;
      @(negedge clk);
      rst = 0;
      clear_model();
      last_addr = 0;
      last_data = 0;
      check_reset_outputs();
      return;
    end
    @(negedge clk);
    if (idx < NR) begin
      exp_count++;
      if (exp_count == NR) exp_done = 1;
    end
    check("busy_idle", busy, 0);
    check("we_idle", res_we, 0);
    check("done", done, exp_done);
    check("ready_after", in_ready, !exp_done);
    check("hold_addr", res_addr, last_addr);
    check("hold_data", res_data, last_data);
  endtask
  function automatic logic [N*DATA_W-1:0] rand_vec();
    logic [N*DATA_W-1:0] v;
    for (int i = 0; i < N; i++)
      v[i*DATA_W +: DATA_W] = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
    return v;
  endfunction
  initial begin
    int g;
    rst = 1;
    start = 0;
    in_valid = 0;
    a_i = '0;
    b_j = '0;
    in_idx = '0;
    clear_model();
    last_addr = 0;
    last_data = 0;
    repeat (2) @(negedge clk);
    check_reset_outputs();
    rst = 0;
    @(negedge clk);
    txn(pack(1, 2, 3), pack(4, 5, 6), 0, 0);
    check("dir_32", res_data, 32'h20);
    txn(pack(1, 1, 1), pack(1, 1, 1), 9, 0);
    check("bad_idx_addr", res_addr, 0);
    txn(pack(16'hFFFF, 16'hFFFF, 16'hFFFF), pack(16'hFFFF, 16'hFFFF, 16'hFFFF), 1, 0);
`ifdef MAC_SAT_EN
    check("dir_sat_data", res_data, 32'hFFFF_FFFF);
    check("dir_sat_flag", sat_flag, 1);
`else
    check("dir_wrap_data", res_data, 32'hFFFA_0003);
    check("dir_wrap_flag", sat_flag, 0);
`endif
    in_valid = 1;
    start = 1;
    @(negedge clk);
    in_valid = 0;
    start = 0;
    clear_model();
    check("start_vs_valid_busy", busy, 0);
    check("start_vs_valid_ready", in_ready, 1);
    txn(pack(5, 6, 7), pack(8, 9, 10), 2, 1);
    txn(pack(7, 8, 9), pack(1, 2, 3), 2, 0);
    check("after_abort_data", res_data, 50);
    do_start();
    for (int i = 0; i < NR; i++) txn(rand_vec(), rand_vec(), IDX_W'(i), 0);
    check("seq_done", done, 1);
    in_valid = 1;
    repeat (3) begin
      @(negedge clk);
      check("post_done_busy", busy, 0);
      check("post_done_ready", in_ready, 0);
    end
    in_valid = 0;
    do_start();
    repeat (3) begin
      g = 0;
      while (!exp_done && g < 60) begin
        txn(rand_vec(), rand_vec(), IDX_W'($urandom_range(0, 11)), 0);
        g++;
      end
      check("rand_done", done, 1);
      do_start();
    end
    txn(pack(2, 3, 4), pack(5, 6, 7), 3, 2);
    txn(pack(1, 0, 2), pack(3, 9, 4), 4, 0);
    check("after_rst_data", res_data, 11);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
